// File: rtl/sram_cell_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// sram_cell_access_ctrl_if
// Request/response bundle between a requester and sram_cell_access_ctrl.
//   req_valid  requester -> ctrl   request present
//   req_ready  ctrl -> requester   controller idle and able to accept
//   req_we     requester -> ctrl   1 = write, 0 = read
//   req_wdata  requester -> ctrl   bit to write
//   rsp_valid  ctrl -> requester   one-cycle completion pulse
//   rsp_rdata  ctrl -> requester   sampled (read) or written (write) bit
//   rsp_err    ctrl -> requester   read sample invalid
// ---------------------------------------------------------------------------
interface sram_cell_access_ctrl_if;
   logic req_valid;
   logic req_ready;
   logic req_we;
   logic req_wdata;
   logic rsp_valid;
   logic rsp_rdata;
   logic rsp_err;

   modport master (
      output req_valid, req_we, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/sram_cell_access_ctrl.sv
// ---------------------------------------------------------------------------
// sram_cell_access_ctrl
// Access sequencer for a single 6T SRAM cell. Takes one read/write request at a
// time, drives the bitline pair and pulses the wordline, and returns a
// one-cycle response with the read (or written) bit and an error flag.
//
// Ports
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    request/response interface (slave side)
//   busy   high in every state other than IDLE
//   WL     wordline, registered
//   BL/BR  bitline pair, tri-stated when not driven
//
// Parameters
//   WL_CYC  cycles WL is high during a write (>= 1)
//   RD_CYC  cycles WL is high during a read before sampling (>= 1)
//
// Build option
//   SRAM_CTRL_READBACK_EN  when defined, every write is followed by a read of
//                          the cell; the response reports the read-back bit
//                          and flags a mismatch with the written bit.
//
// State  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a request, req_ready high
// SETUP  | write: bitlines driven, WL low
// WL_ON  | WL high, counter runs; write or read timing
// HOLD   | write: WL low, bitlines still driven
// FLOAT  | read: bitlines released, WL low
// DONE   | response pulse, back to IDLE
// ---------------------------------------------------------------------------
module sram_cell_access_ctrl #(
   parameter int WL_CYC = 2,
   parameter int RD_CYC = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   sram_cell_access_ctrl_if.slave  bus,
   output logic                    busy,
   output logic                    WL,
   inout  wire                     BL,
   inout  wire                     BR
);

   localparam int CNT_MAX = (WL_CYC > RD_CYC) ? WL_CYC : RD_CYC;
   localparam int CW      = (CNT_MAX + 1 > 2) ? $clog2(CNT_MAX + 1) : 1;
   localparam logic [CW-1:0] WL_LOAD = CW'(WL_CYC - 1);
   localparam logic [CW-1:0] RD_LOAD = CW'(RD_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_WL_ON,
      S_HOLD,
      S_FLOAT,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            we_q, we_d;
   logic            wdata_q, wdata_d;
   logic            rd_phase_q, rd_phase_d;   // WL_ON belongs to a read (sample at its end)
   logic            drv_en_q, drv_en_d;
   logic            wl_q, wl_d;
   logic            rdata_q, rdata_d;
   logic            err_q, err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         wdata_q    <= 1'b0;
         rd_phase_q <= 1'b0;
         drv_en_q   <= 1'b0;
         wl_q       <= 1'b0;
         rdata_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         rd_phase_q <= rd_phase_d;
         drv_en_q   <= drv_en_d;
         wl_q       <= wl_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      rd_phase_d = rd_phase_q;
      rdata_d    = rdata_q;
      err_d      = err_q;

      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               we_d       = bus.req_we;
               wdata_d    = bus.req_wdata;
               rd_phase_d = ~bus.req_we;
               state_d    = bus.req_we ? S_SETUP : S_FLOAT;
            end
         end
         S_SETUP: begin
            state_d = S_WL_ON;
            cnt_d   = WL_LOAD;
         end
         S_FLOAT: begin
            state_d    = S_WL_ON;
            cnt_d      = RD_LOAD;
            rd_phase_d = 1'b1;
         end
         S_WL_ON: begin
            if (cnt_q == '0) begin
               if (rd_phase_q) begin
                  // Sample on the edge that ends the last WL_ON cycle.
                  state_d = S_DONE;
                  rdata_d = BL;
`ifdef SRAM_CTRL_READBACK_EN
                  err_d   = (BL == BR) | (we_q & (BL != wdata_q));
`else
                  err_d   = (BL == BR);
`endif
               end else begin
                  state_d = S_HOLD;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_HOLD: begin
`ifdef SRAM_CTRL_READBACK_EN
            state_d = S_FLOAT;
`else
            state_d = S_DONE;
            rdata_d = wdata_q;
            err_d   = 1'b0;
`endif
         end
         S_DONE: begin
            state_d    = S_IDLE;
            rd_phase_d = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Output registers are loaded from the next state so that WL and the
      // driver enables switch on the same edge as the state, never together:
      // the drivers are only turned on/off on edges where WL is (or goes) low.
      wl_d     = (state_d == S_WL_ON);
      drv_en_d = we_d & ~rd_phase_d &
                 ((state_d == S_SETUP) | (state_d == S_WL_ON) | (state_d == S_HOLD));
   end

   assign BL = drv_en_q ? wdata_q  : 1'bz;
   assign BR = drv_en_q ? ~wdata_q : 1'bz;
   assign WL = wl_q;

   assign busy          = (state_q != S_IDLE);
   assign bus.req_ready = (state_q == S_IDLE) & rst_n;
   assign bus.rsp_valid = (state_q == S_DONE);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_sram_cell_access_ctrl.sv
module tb_sram_cell_access_ctrl;

   localparam int WL_CYC = 2;
   localparam int RD_CYC = 2;
`ifdef SRAM_CTRL_READBACK_EN
   localparam int LAT_WR = WL_CYC + RD_CYC + 4;
`else
   localparam int LAT_WR = WL_CYC + 3;
`endif
   localparam int LAT_RD = RD_CYC + 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy;
   logic WL;
   wire  BL;
   wire  BR;

   sram_cell_access_ctrl_if bus ();

   sram_cell_access_ctrl #(.WL_CYC(WL_CYC), .RD_CYC(RD_CYC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy),
      .WL    (WL),
      .BL    (BL),
      .BR    (BR)
   );

   always #5 clk = ~clk;

   // Cell model: undriven bitlines float high; while WL is high in a read
   // phase the cell drives its content, in a write phase it stores BL.
   logic cell_q    = 1'b0;
   logic cell_mode = 1'b0;
   logic force11   = 1'b0;
   logic bl_low    = 1'b0;

   pullup (BL);
   pullup (BR);
   assign BL = (WL && cell_mode) ? (force11 ? 1'b1 : (bl_low ? 1'b0 : cell_q)) : 1'bz;
   assign BR = (WL && cell_mode) ? (force11 ? 1'b1 : ~cell_q) : 1'bz;

   always @(posedge clk) if (WL && !cell_mode) cell_q <= BL;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   typedef struct {
      logic  rdata;
      logic  err;
      int    cyc;
      string tag;
   } exp_t;

   exp_t sb[$];

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && bus.rsp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp at cyc=%0d rdata=%0b err=%0b", cyc, bus.rsp_rdata, bus.rsp_err);
         end else begin
            e = sb.pop_front();
            chk({e.tag, "_rdata"}, bus.rsp_rdata, e.rdata);
            chk({e.tag, "_err"}, bus.rsp_err, e.err);
            chk_int({e.tag, "_rsp_cycle"}, cyc, e.cyc);
         end
      end
   end

   int wait_n;
   int last_e;

   function automatic logic wl_exp(input logic we, input int k);
      if (!we) return (k >= 2 && k <= RD_CYC + 1);
`ifdef SRAM_CTRL_READBACK_EN
      if (k >= WL_CYC + 4 && k <= WL_CYC + RD_CYC + 3) return 1'b1;
`endif
      return (k >= 2 && k <= WL_CYC + 1);
   endfunction

   // Issue one request from a negedge, then check every cycle of the operation.
   // abort_k > 0 asserts reset in that cycle and expects no response.
   task automatic do_op(input logic we, input logic wd, input logic keep, input int abort_k,
                        input logic exp_rd, input logic exp_err, input string tag);
      int n;
      int lat;
      int e;
      logic wle;
      lat = we ? LAT_WR : LAT_RD;
      bus.req_we    = we;
      bus.req_wdata = wd;
      bus.req_valid = 1'b1;
      cell_mode     = ~we;
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         chk({tag, "_accept_timeout"}, bus.req_ready, 1'b1);
         bus.req_valid = 1'b0;
         return;
      end
      wait_n = n;
      @(posedge clk);
      #1;
      e = cyc;
      last_e = e;
      if (abort_k == 0) sb.push_back('{exp_rd, exp_err, e + lat - 1, tag});
      if (!keep) bus.req_valid = 1'b0;
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         wle = wl_exp(we, k);
         chk({tag, "_ready_low"}, bus.req_ready, 1'b0);
         chk({tag, "_busy"}, busy, 1'b1);
         chk({tag, "_wl"}, WL, wle);
         if (we && k <= WL_CYC + 2) begin
            chk({tag, "_bl_drv"}, BL, wd);
            chk({tag, "_br_drv"}, BR, ~wd);
         end else if (!wle) begin
            chk({tag, "_bl_z"}, BL, 1'b1);
            chk({tag, "_br_z"}, BR, 1'b1);
         end
`ifdef SRAM_CTRL_READBACK_EN
         if (we && k == WL_CYC + 3) cell_mode = 1'b1;
`endif
         if (k == abort_k) begin
            rst_n = 1'b0;
            bus.req_valid = 1'b0;
            #1;
            chk({tag, "_rst_wl"}, WL, 1'b0);
            chk({tag, "_rst_bl_z"}, BL, 1'b1);
            chk({tag, "_rst_br_z"}, BR, 1'b1);
            cell_mode = 1'b0;
            return;
         end
      end
      cell_mode = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int e1;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_wdata = 1'b0;
      #1;
      chk("reset_wl", WL, 1'b0);
      chk("reset_bl_z", BL, 1'b1);
      chk("reset_br_z", BR, 1'b1);
      chk("reset_busy", busy, 1'b0);
      chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
      chk("reset_rsp_rdata", bus.rsp_rdata, 1'b0);
      chk("reset_rsp_err", bus.rsp_err, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset_ready", bus.req_ready, 1'b1);
      @(negedge clk);

      // 1: write 1
      do_op(1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, "t1_wr1");
      // 2: read back
      do_op(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, "t2_rd");
      // 3: write 0, read, then invalid sample
      do_op(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, "t3_wr0");
      do_op(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, "t3_rd0");
      force11 = 1'b1;
      do_op(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, "t3_rd11");
      force11 = 1'b0;

      // 4: req_valid held through a write
      do_op(1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b0, "t4_wr1");
      e1 = last_e;
      do_op(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, "t4_rd");
      chk_int("t4_wait_cycles", wait_n, 1);
      chk_int("t4_accept_spacing", last_e - e1, LAT_WR + 1);

      // 5: reset during WL_ON of a write
      do_op(1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, "t5_wr_abort");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("t5_ready_after", bus.req_ready, 1'b1);
      chk("t5_busy_after", busy, 1'b0);
      chk("t5_rdata_after", bus.rsp_rdata, 1'b0);
      repeat (8) @(negedge clk);
      do_op(1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, "t5_wr1");
      do_op(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, "t5_rd");

`ifdef SRAM_CTRL_READBACK_EN
      // 6: readback build
      do_op(1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, "t6_wr1_rb");
      bl_low = 1'b1;
      do_op(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1, "t6_wr1_rb_bad");
      bl_low = 1'b0;
`endif

      repeat (10) @(negedge clk);
      chk_int("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
